// File: rtl/ram_wb_dual_pkg.sv
// Shared definitions for the dual-port Wishbone RAM: byte width, port IDs,
// per-port FSM states and read-latency normalisation.
package ram_wb_dual_pkg;

    localparam int   BYTE_W = 8;
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } port_state_t;

    // Only 1 and 2 are meaningful; anything else folds onto the nearer one.
    function automatic int clamp_latency(input int lat);
        return (lat >= 2) ? 2 : 1;
    endfunction

endpackage

// File: rtl/ram_sp_array.sv
// Single-port byte-enabled synchronous array with optional output register.
// This is the only place an SRAM macro needs to be swapped in.
module ram_sp_array
    import ram_wb_dual_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH_WORDS  = 16384,
    parameter int AW           = 14,
    parameter int READ_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         en,
    input  logic                         we,
    input  logic [DATA_WIDTH/BYTE_W-1:0] sel,
    input  logic [AW-1:0]                addr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    output logic [DATA_WIDTH-1:0]        rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
    logic [DATA_WIDTH-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < DATA_WIDTH / BYTE_W; i++)
                    if (sel[i]) mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
            end else begin
                rd_q <= mem[addr];
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_oreg
            logic [DATA_WIDTH-1:0] out_q;
            always_ff @(posedge clk) out_q <= rd_q;
            assign rdata = out_q;
        end else begin : g_direct
            assign rdata = rd_q;
        end
    endgenerate

endmodule

// File: rtl/ram_wb_dual.sv
// Two Wishbone-classic masters (A read-only, B read/write) round-robin
// arbitrated onto one single-port array; out-of-range words answer with err.
module ram_wb_dual
    import ram_wb_dual_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH_WORDS  = 16384,
    parameter int READ_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         a_cyc,
    input  logic                         a_stb,
    input  logic [ADDR_WIDTH-1:0]        a_addr,
    output logic [DATA_WIDTH-1:0]        a_rdata,
    output logic                         a_ack,
    output logic                         a_err,
    input  logic                         b_cyc,
    input  logic                         b_stb,
    input  logic                         b_we,
    input  logic [DATA_WIDTH/BYTE_W-1:0] b_sel,
    input  logic [ADDR_WIDTH-1:0]        b_addr,
    input  logic [DATA_WIDTH-1:0]        b_wdata,
    output logic [DATA_WIDTH-1:0]        b_rdata,
    output logic                         b_ack,
    output logic                         b_err
);

    localparam int NB  = DATA_WIDTH / BYTE_W;
    localparam int OFF = $clog2(NB);
    localparam int WW  = ADDR_WIDTH - OFF;
    localparam int AW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int LAT = clamp_latency(READ_LATENCY);
    localparam logic [WW:0] DEPTH_L = DEPTH_WORDS[WW:0];

    port_state_t a_st, a_st_nx, b_st, b_st_nx;
    logic        last;
    logic        req_a, req_b, gnt_a, gnt_b, in_rng;
    logic        kill_a, kill_b, done_a, done_b;
    logic [WW-1:0] a_idx, b_idx, iss_idx;
    logic [LAT:1]  vld_pipe, port_pipe, err_pipe, live;
    logic [DATA_WIDTH-1:0] arr_rdata;
    logic unused_bits;

    assign a_idx   = a_addr[ADDR_WIDTH-1:OFF];
    assign b_idx   = b_addr[ADDR_WIDTH-1:OFF];
    assign req_a   = a_cyc & a_stb & (a_st == ST_IDLE);
    assign req_b   = b_cyc & b_stb & (b_st == ST_IDLE);
    // Contention goes to whichever port was not granted last.
    assign gnt_a   = req_a & (~req_b | (last == PORT_B));
    assign gnt_b   = req_b & ~gnt_a;
    assign iss_idx = gnt_b ? b_idx : a_idx;
    assign in_rng  = ({1'b0, iss_idx} < DEPTH_L);
    assign kill_a  = (a_st == ST_WAIT) & ~a_cyc;
    assign kill_b  = (b_st == ST_WAIT) & ~b_cyc;
    assign unused_bits = ^{a_addr, b_addr, iss_idx};

    ram_sp_array #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW),
        .READ_LATENCY(LAT)
    ) u_array (
        .clk  (clk),
        .en   ((gnt_a | gnt_b) & in_rng),
        .we   (gnt_b & b_we),
        .sel  (b_sel),
        .addr (iss_idx[AW-1:0]),
        .wdata(b_wdata),
        .rdata(arr_rdata)
    );

    // An abort removes that port's in-flight entries so a re-issue cannot see a stale ack.
    always_comb begin
        live = vld_pipe;
        for (int i = 1; i <= LAT; i++)
            if (port_pipe[i] ? kill_b : kill_a) live[i] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            port_pipe <= '0;
            err_pipe  <= '0;
            last      <= PORT_B;
        end else begin
            vld_pipe[1]  <= gnt_a | gnt_b;
            port_pipe[1] <= gnt_b ? PORT_B : PORT_A;
            err_pipe[1]  <= ~in_rng;
            for (int i = 2; i <= LAT; i++) begin
                vld_pipe[i]  <= live[i-1];
                port_pipe[i] <= port_pipe[i-1];
                err_pipe[i]  <= err_pipe[i-1];
            end
            if (gnt_a)      last <= PORT_A;
            else if (gnt_b) last <= PORT_B;
        end
    end

    assign done_a  = vld_pipe[LAT] & (port_pipe[LAT] == PORT_A);
    assign done_b  = vld_pipe[LAT] & (port_pipe[LAT] == PORT_B);
    assign a_ack   = live[LAT] & (port_pipe[LAT] == PORT_A) & ~err_pipe[LAT];
    assign a_err   = live[LAT] & (port_pipe[LAT] == PORT_A) &  err_pipe[LAT];
    assign b_ack   = live[LAT] & (port_pipe[LAT] == PORT_B) & ~err_pipe[LAT];
    assign b_err   = live[LAT] & (port_pipe[LAT] == PORT_B) &  err_pipe[LAT];
    assign a_rdata = a_ack ? arr_rdata : '0;
    assign b_rdata = b_ack ? arr_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_st <= ST_IDLE;
            b_st <= ST_IDLE;
        end else begin
            a_st <= a_st_nx;
            b_st <= b_st_nx;
        end
    end

    always_comb begin
        a_st_nx = a_st;
        b_st_nx = b_st;
        case (a_st)
            ST_IDLE: if (gnt_a) a_st_nx = ST_WAIT;
            ST_WAIT: if (done_a | kill_a) a_st_nx = ST_IDLE;
            default: a_st_nx = ST_IDLE;
        endcase
        case (b_st)
            ST_IDLE: if (gnt_b) b_st_nx = ST_WAIT;
            ST_WAIT: if (done_b | kill_b) b_st_nx = ST_IDLE;
            default: b_st_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_wb_dual.sv
// Directed bench: instance 0 uses READ_LATENCY=1, instance 1 READ_LATENCY=2.
module tb_ram_wb_dual;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]  a_cyc, a_stb, a_ack, a_err, b_cyc, b_stb, b_we, b_ack, b_err;
    logic [16:0] a_addr [2];
    logic [16:0] b_addr [2];
    logic [31:0] a_rdata [2];
    logic [31:0] b_rdata [2];
    logic [31:0] b_wdata [2];
    logic [3:0]  b_sel [2];
    int checks = 0;
    int failures = 0;

    ram_wb_dual #(.ADDR_WIDTH(17), .DATA_WIDTH(32), .DEPTH_WORDS(16384), .READ_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .a_cyc(a_cyc[0]), .a_stb(a_stb[0]), .a_addr(a_addr[0]), .a_rdata(a_rdata[0]),
        .a_ack(a_ack[0]), .a_err(a_err[0]),
        .b_cyc(b_cyc[0]), .b_stb(b_stb[0]), .b_we(b_we[0]), .b_sel(b_sel[0]),
        .b_addr(b_addr[0]), .b_wdata(b_wdata[0]), .b_rdata(b_rdata[0]),
        .b_ack(b_ack[0]), .b_err(b_err[0]));

    ram_wb_dual #(.ADDR_WIDTH(17), .DATA_WIDTH(32), .DEPTH_WORDS(16384), .READ_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst),
        .a_cyc(a_cyc[1]), .a_stb(a_stb[1]), .a_addr(a_addr[1]), .a_rdata(a_rdata[1]),
        .a_ack(a_ack[1]), .a_err(a_err[1]),
        .b_cyc(b_cyc[1]), .b_stb(b_stb[1]), .b_we(b_we[1]), .b_sel(b_sel[1]),
        .b_addr(b_addr[1]), .b_wdata(b_wdata[1]), .b_rdata(b_rdata[1]),
        .b_ack(b_ack[1]), .b_err(b_err[1]));

    task automatic drive(input int d, input bit pb, input bit on, input bit we,
                         input logic [3:0] sel, input logic [16:0] addr, input logic [31:0] wd);
        if (pb) begin
            b_cyc[d] = on; b_stb[d] = on; b_we[d] = we;
            b_sel[d] = sel; b_addr[d] = addr; b_wdata[d] = wd;
        end else begin
            a_cyc[d] = on; a_stb[d] = on; a_addr[d] = addr;
        end
    endtask

    // One bounded transfer starting at a negedge; lat = samples until ack/err (0 = none).
    task automatic xfer(input int d, input bit pb, input bit we, input logic [3:0] sel,
                        input logic [16:0] addr, input logic [31:0] wd,
                        output logic ack, output logic err, output logic [31:0] rd, output int lat);
        ack = 0; err = 0; rd = 0; lat = 0;
        drive(d, pb, 1, we, sel, addr, wd);
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            ack = pb ? b_ack[d] : a_ack[d];
            err = pb ? b_err[d] : a_err[d];
            rd  = pb ? b_rdata[d] : a_rdata[d];
            if (ack | err) lat = k;
        end
        drive(d, pb, 0, 0, 4'h0, addr, wd);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({a_ack, a_err, b_ack, b_err} !== 8'h00) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 00000000", {a_ack, a_err, b_ack, b_err});
        end
        checks++;
        if ({a_rdata[0], b_rdata[0], a_rdata[1], b_rdata[1]} !== 128'h0) begin
            failures++;
            $display("FAIL reset_rdata: got %h %h expected 0", a_rdata[0], b_rdata[0]);
        end
        rst = 0;
        @(negedge clk);
        checks++;
        if ({a_ack, a_err, b_ack, b_err} !== 8'h00) begin
            failures++;
            $display("FAIL post_reset_flags: got %b expected 00000000", {a_ack, a_err, b_ack, b_err});
        end
    endtask

    task automatic test_write_read;
        logic ack, err; logic [31:0] rd; int lat;
        xfer(0, 1, 1, 4'hF, 17'h00010, 32'hDEADBEEF, ack, err, rd, lat);
        checks++;
        if (ack !== 1 || err !== 0 || lat != 1) begin
            failures++;
            $display("FAIL wr_ack: got ack=%b err=%b lat=%0d expected 1 0 1", ack, err, lat);
        end
        xfer(0, 0, 0, 4'h0, 17'h00010, 32'h0, ack, err, rd, lat);
        checks++;
        if (ack !== 1 || lat != 1) begin
            failures++;
            $display("FAIL a_rd_ack: got ack=%b lat=%0d expected 1 1", ack, lat);
        end
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL a_rd_data: got %h expected deadbeef", rd);
        end
    endtask

    task automatic test_byte_enable;
        logic ack, err; logic [31:0] rd; int lat;
        xfer(0, 1, 1, 4'hF, 17'h00020, 32'h11223344, ack, err, rd, lat);
        xfer(0, 1, 1, 4'b0001, 17'h00020, 32'h000000AA, ack, err, rd, lat);
        xfer(0, 1, 0, 4'h0, 17'h00020, 32'h0, ack, err, rd, lat);
        checks++;
        if (rd !== 32'h112233AA) begin
            failures++;
            $display("FAIL sel_0001: got %h expected 112233aa", rd);
        end
        xfer(0, 1, 1, 4'b0000, 17'h00020, 32'hFFFFFFFF, ack, err, rd, lat);
        checks++;
        if (ack !== 1 || lat != 1) begin
            failures++;
            $display("FAIL sel_0000_ack: got ack=%b lat=%0d expected 1 1", ack, lat);
        end
        xfer(0, 1, 0, 4'h0, 17'h00020, 32'h0, ack, err, rd, lat);
        checks++;
        if (rd !== 32'h112233AA) begin
            failures++;
            $display("FAIL sel_0000_data: got %h expected 112233aa", rd);
        end
        xfer(0, 1, 1, 4'b1010, 17'h00040, 32'h55667788, ack, err, rd, lat);
        xfer(0, 1, 1, 4'b1010, 17'h00040, 32'hCCDDEEFF, ack, err, rd, lat);
        xfer(0, 1, 1, 4'b0101, 17'h00040, 32'h00220099, ack, err, rd, lat);
        xfer(0, 1, 0, 4'h0, 17'h00040, 32'h0, ack, err, rd, lat);
        checks++;
        if (rd !== 32'hCC22EE99) begin
            failures++;
            $display("FAIL sel_mixed: got %h expected cc22ee99", rd);
        end
    endtask

    // Both masters hold requests; last grant was B, so A leads and acks alternate.
    task automatic test_interleave;
        bit exp_a;
        drive(0, 0, 1, 0, 4'h0, 17'h00010, 32'h0);
        drive(0, 1, 1, 0, 4'h0, 17'h00020, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_a = (k % 2) == 1;
            checks++;
            if (a_ack[0] !== exp_a || b_ack[0] !== !exp_a) begin
                failures++;
                $display("FAIL interleave_ack[%0d]: got a=%b b=%b expected a=%b b=%b",
                         k, a_ack[0], b_ack[0], exp_a, !exp_a);
            end
            checks++;
            if (exp_a ? (a_rdata[0] !== 32'hDEADBEEF) : (b_rdata[0] !== 32'h112233AA)) begin
                failures++;
                $display("FAIL interleave_data[%0d]: got a=%h b=%h", k, a_rdata[0], b_rdata[0]);
            end
        end
        drive(0, 0, 0, 0, 4'h0, 17'h00010, 32'h0);
        drive(0, 1, 0, 0, 4'h0, 17'h00020, 32'h0);
        @(negedge clk);
    endtask

    // A lone access moves the pointer; the next contention goes to the other port.
    task automatic test_rr_pointer;
        logic ack, err; logic [31:0] rd; int lat;
        bit first_b;
        for (int r = 0; r < 2; r++) begin
            first_b = (r == 0);
            xfer(0, !first_b, 0, 4'h0, first_b ? 17'h00010 : 17'h00020, 32'h0, ack, err, rd, lat);
            drive(0, 0, 1, 0, 4'h0, 17'h00010, 32'h0);
            drive(0, 1, 1, 0, 4'h0, 17'h00020, 32'h0);
            @(negedge clk);
            checks++;
            if (a_ack[0] !== !first_b || b_ack[0] !== first_b) begin
                failures++;
                $display("FAIL rr_first[%0d]: got a=%b b=%b expected a=%b b=%b",
                         r, a_ack[0], b_ack[0], !first_b, first_b);
            end
            drive(0, first_b, 0, 0, 4'h0, 17'h00010, 32'h0);
            @(negedge clk);
            checks++;
            if (a_ack[0] !== first_b || b_ack[0] !== !first_b) begin
                failures++;
                $display("FAIL rr_second[%0d]: got a=%b b=%b expected a=%b b=%b",
                         r, a_ack[0], b_ack[0], first_b, !first_b);
            end
            drive(0, !first_b, 0, 0, 4'h0, 17'h00010, 32'h0);
            @(negedge clk);
        end
    endtask

    task automatic test_out_of_range;
        logic ack, err; logic [31:0] rd; int lat;
        xfer(0, 1, 1, 4'hF, 17'h00000, 32'h01020304, ack, err, rd, lat);
        xfer(0, 1, 0, 4'h0, 17'h10000, 32'h0, ack, err, rd, lat);
        checks++;
        if (err !== 1 || ack !== 0 || rd !== 32'h0 || lat != 1) begin
            failures++;
            $display("FAIL oor_read: got err=%b ack=%b rd=%h lat=%0d expected 1 0 0 1", err, ack, rd, lat);
        end
        xfer(0, 1, 1, 4'hF, 17'h10000, 32'h77777777, ack, err, rd, lat);
        checks++;
        if (err !== 1 || ack !== 0) begin
            failures++;
            $display("FAIL oor_write: got err=%b ack=%b expected 1 0", err, ack);
        end
        xfer(0, 0, 0, 4'h0, 17'h00000, 32'h0, ack, err, rd, lat);
        checks++;
        if (rd !== 32'h01020304) begin
            failures++;
            $display("FAIL oor_no_alias: got %h expected 01020304", rd);
        end
        xfer(0, 0, 0, 4'h0, 17'h1FFFC, 32'h0, ack, err, rd, lat);
        checks++;
        if (err !== 1 || ack !== 0 || rd !== 32'h0) begin
            failures++;
            $display("FAIL oor_a: got err=%b ack=%b rd=%h expected 1 0 0", err, ack, rd);
        end
        xfer(0, 1, 1, 4'hF, 17'h0FFFC, 32'h0BADF00D, ack, err, rd, lat);
        xfer(0, 0, 0, 4'h0, 17'h0FFFF, 32'h0, ack, err, rd, lat);
        checks++;
        if (ack !== 1 || err !== 0 || rd !== 32'h0BADF00D) begin
            failures++;
            $display("FAIL last_word: got ack=%b err=%b rd=%h expected 1 0 0badf00d", ack, err, rd);
        end
    endtask

    task automatic test_latency2;
        logic ack, err; logic [31:0] rd; int lat, n;
        xfer(1, 1, 1, 4'hF, 17'h00040, 32'hCAFEF00D, ack, err, rd, lat);
        checks++;
        if (ack !== 1 || lat != 2) begin
            failures++;
            $display("FAIL l2_wr: got ack=%b lat=%0d expected 1 2", ack, lat);
        end
        xfer(1, 0, 0, 4'h0, 17'h00040, 32'h0, ack, err, rd, lat);
        checks++;
        if (ack !== 1 || lat != 2 || rd !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL l2_rd: got ack=%b lat=%0d rd=%h expected 1 2 cafef00d", ack, lat, rd);
        end
        n = 0;
        drive(1, 0, 1, 0, 4'h0, 17'h00040, 32'h0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            n += int'(a_ack[1]);
            checks++;
            if (a_ack[1] !== ((k % 3) == 2) || (a_ack[1] && a_rdata[1] !== 32'hCAFEF00D)) begin
                failures++;
                $display("FAIL l2_b2b[%0d]: got ack=%b rd=%h expected ack=%b", k, a_ack[1], a_rdata[1], (k % 3) == 2);
            end
        end
        drive(1, 0, 0, 0, 4'h0, 17'h00040, 32'h0);
        @(negedge clk);
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL l2_b2b_count: got %0d expected 3", n);
        end
    endtask

    task automatic test_abort;
        logic ack, err; logic [31:0] rd; int lat;
        drive(1, 0, 1, 0, 4'h0, 17'h00040, 32'h0);
        @(negedge clk);
        drive(1, 0, 0, 0, 4'h0, 17'h00040, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (a_ack[1] !== 0 || a_err[1] !== 0) begin
                failures++;
                $display("FAIL abort_no_ack[%0d]: got ack=%b err=%b expected 0 0", k, a_ack[1], a_err[1]);
            end
        end
        drive(1, 1, 1, 1, 4'hF, 17'h00044, 32'h13579BDF);
        @(negedge clk);
        drive(1, 1, 0, 0, 4'h0, 17'h00044, 32'h0);
        @(negedge clk); @(negedge clk);
        xfer(1, 0, 0, 4'h0, 17'h00044, 32'h0, ack, err, rd, lat);
        checks++;
        if (ack !== 1 || lat != 2 || rd !== 32'h13579BDF) begin
            failures++;
            $display("FAIL abort_committed: got ack=%b lat=%0d rd=%h expected 1 2 13579bdf", ack, lat, rd);
        end
    endtask

    task automatic test_reset_mid_write;
        logic ack, err; logic [31:0] rd; int lat;
        drive(0, 1, 1, 1, 4'hF, 17'h00030, 32'h5A5A5A5A);
        @(posedge clk);
        #1 rst = 1;
        drive(0, 1, 0, 0, 4'h0, 17'h00030, 32'h0);
        #2;
        checks++;
        if (b_ack[0] !== 0 || b_err[0] !== 0 || b_rdata[0] !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid: got ack=%b err=%b rd=%h expected 0 0 0", b_ack[0], b_err[0], b_rdata[0]);
        end
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        xfer(0, 0, 0, 4'h0, 17'h00030, 32'h0, ack, err, rd, lat);
        checks++;
        if (ack !== 1 || rd !== 32'h5A5A5A5A) begin
            failures++;
            $display("FAIL rst_committed: got ack=%b rd=%h expected 1 5a5a5a5a", ack, rd);
        end
    endtask

    initial begin
        rst = 1;
        a_cyc = '0; a_stb = '0; b_cyc = '0; b_stb = '0; b_we = '0;
        for (int i = 0; i < 2; i++) begin
            a_addr[i] = '0; b_addr[i] = '0; b_wdata[i] = '0; b_sel[i] = '0;
        end
        test_reset;
        test_write_read;
        test_byte_enable;
        test_interleave;
        test_rr_pointer;
        test_out_of_range;
        test_latency2;
        test_abort;
        test_reset_mid_write;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
